dm_arbiter: RTL



---
 rtl/dm_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dm_arbiter
// Desc    : Shares the data-memory port between CPU (C) and DMA (D) requesters
//           via req/ack. Define DM_ARB_ROUND_ROBIN_EN for round-robin ties.
// Rev     : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interupt,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [1:0]  c_size,
    input  logic [31:0] c_wdata,
    output logic        c_ack,
    output logic        c_err,
    output logic [31:0] c_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,

    output logic [29:0] dm_A,
    output logic [31:0] dm_WD,
    output logic        dm_we,
    output logic [3:0]  dm_BE,
    input  logic [31:0] dm_RD
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_go;
    logic        w_pick_d;
    logic        w_we;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic [31:0] w_wdata;
    logic        w_err;
    logic [3:0]  w_be;
    logic        w_in_acc;
    logic        w_in_done;

    logic        r_gnt_d;
    logic        r_we;
    logic        r_err;
    logic [3:0]  r_be;
    logic [29:0] r_A;
    logic [31:0] r_WD;
    logic [31:0] r_rdata;

    assign w_go = (r_state == IDLE) && !interupt && (c_req || d_req);

`ifdef DM_ARB_ROUND_ROBIN_EN
    // High when D holds priority for the next tie; reset leaves C first.
    logic r_prio_d;

    always_comb begin
        w_pick_d = d_req;
        if (c_req && d_req) begin
            w_pick_d = r_prio_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_d <= 1'b0;
        end else if (w_go) begin
            r_prio_d <= ~w_pick_d;
        end
    end
`else
    assign w_pick_d = ~c_req;
`endif

    always_comb begin
        w_we    = c_we;
        w_addr  = c_addr;
        w_size  = c_size;
        w_wdata = c_wdata;
        if (w_pick_d) begin
            w_we    = d_we;
            w_addr  = d_addr;
            w_size  = d_size;
            w_wdata = d_wdata;
        end
    end

    always_comb begin
        w_be  = 4'b0000;
        w_err = 1'b0;
        case (w_size)
            2'b00: w_be = 4'b0001 << w_addr[1:0];
            2'b01: begin
                w_be  = w_addr[1] ? 4'b1100 : 4'b0011;
                w_err = w_addr[0];
            end
            2'b10: begin
                w_be  = 4'b1111;
                w_err = |w_addr[1:0];
            end
            default: w_err = 1'b1;
        endcase
        if (w_addr >= ADDR_LIMIT) begin
            w_err = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_go) w_state_nxt = ACC;
            ACC:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request attributes are frozen at grant so the memory side is stable in ACC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_d <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_be    <= 4'b0000;
            r_A     <= 30'd0;
            r_WD    <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            if (w_go) begin
                r_gnt_d <= w_pick_d;
                r_we    <= w_we;
                r_err   <= w_err;
                r_be    <= w_be;
                r_A     <= w_addr[31:2];
                r_WD    <= w_wdata;
            end
            if (r_state == ACC) begin
                r_rdata <= r_err ? 32'd0 : dm_RD;
            end
        end
    end

    assign w_in_acc  = (r_state == ACC);
    assign w_in_done = (r_state == DONE);

    assign dm_A    = r_A;
    assign dm_WD   = r_WD;
    assign dm_we   = w_in_acc & r_we & ~r_err;
    assign dm_BE   = w_in_acc ? r_be : 4'b0000;

    assign c_ack   = w_in_done & ~r_gnt_d;
    assign d_ack   = w_in_done &  r_gnt_d;
    assign c_err   = c_ack & r_err;
    assign d_err   = d_ack & r_err;
    assign c_rdata = r_rdata;
    assign d_rdata = r_rdata;

endmodule

`default_nettype wire
